multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// opcode/funct fields, ULA operation codes and the ALUOp bus.
package multicycle_control_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ULA_W   = 3;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ULA_W-1:0] ULA_AND = 3'd0;
  localparam logic [ULA_W-1:0] ULA_OR  = 3'd1;
  localparam logic [ULA_W-1:0] ULA_ADD = 3'd2;
  localparam logic [ULA_W-1:0] ULA_NOR = 3'd3;
  localparam logic [ULA_W-1:0] ULA_SUB = 3'd6;
  localparam logic [ULA_W-1:0] ULA_SLT = 3'd7;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp (and funct for R-type) to a ULA operation; flags unknown funct codes.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ULA_W-1:0]   ula,
  output logic               funct_illegal
);

  always_comb begin
    ula           = ULA_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ula = ULA_ADD;
      ALUOP_SUB: ula = ULA_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ula = ULA_ADD;
          FN_SUB:  ula = ULA_SUB;
          FN_AND:  ula = ULA_AND;
          FN_OR:   ula = ULA_OR;
          FN_NOR:  ula = ULA_NOR;
          FN_SLT:  ula = ULA_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: ula = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM driving datapath selects/strobes,
// with PCEn additionally following the zero flag during BRANCH.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit JUMP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               Z,
  output logic [ULA_W-1:0]   ULAControl,
  output logic               IorD,
  output logic               ALUSrcA,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t               state_q;
  state_t               state_nxt;
  logic [ALUOP_W-1:0]   aluop;
  logic [ULA_W-1:0]     ula_dec;
  logic                 funct_illegal;
  logic                 pcwrite;
  logic                 branch;

  alu_decoder u_alu_decoder (
    .aluop         (aluop),
    .funct         (funct),
    .ula           (ula_dec),
    .funct_illegal (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_nxt;
  end

  // Next state and Moore outputs; everything is held quiet while rst is high.
  always_comb begin
    state_nxt = S_FETCH;
    aluop     = ALUOP_ADD;
    IorD      = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    PCSrc     = 2'b00;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = 1'b1;
        pcwrite   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (op == OP_LW || op == OP_SW) state_nxt = S_MEMADR;
        else if (op == OP_RTYPE)        state_nxt = S_EXECUTE;
        else if (op == OP_BEQ)          state_nxt = S_BRANCH;
        else if (op == OP_ADDI)         state_nxt = S_ADDIEXEC;
        else if (op == OP_J && JUMP_EN) state_nxt = S_JUMP;
        else                            illegal   = 1'b1;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op == OP_LW)      state_nxt = S_MEMREAD;
        else if (op == OP_SW) state_nxt = S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD      = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        if (funct_illegal) illegal   = 1'b1;
        else               state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (rst) begin
      aluop    = ALUOP_ADD;
      IorD     = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      PCSrc    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign ULAControl = ula_dec;
  assign PCEn       = pcwrite | (branch & Z);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (jump enabled / disabled)
// share stimulus; expected values are hand-computed from the instruction timing.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Z;

  logic [2:0] ula1, ula0;
  logic       iord1, srca1, irw1, memw1, regw1, regdst1, m2r1, pcen1, ill1;
  logic       iord0, srca0, irw0, memw0, regw0, regdst0, m2r0, pcen0, ill0;
  logic [1:0] srcb1, pcsrc1, srcb0, pcsrc0;
  logic [3:0] st1, st0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.JUMP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .Z(Z),
    .ULAControl(ula1), .IorD(iord1), .ALUSrcA(srca1), .IRWrite(irw1),
    .MemWrite(memw1), .RegWrite(regw1), .RegDst(regdst1), .MemtoReg(m2r1),
    .ALUSrcB(srcb1), .PCSrc(pcsrc1), .PCEn(pcen1), .illegal(ill1), .state(st1)
  );

  multicycle_control #(.JUMP_EN(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .Z(Z),
    .ULAControl(ula0), .IorD(iord0), .ALUSrcA(srca0), .IRWrite(irw0),
    .MemWrite(memw0), .RegWrite(regw0), .RegDst(regdst0), .MemtoReg(m2r0),
    .ALUSrcB(srcb0), .PCSrc(pcsrc0), .PCEn(pcen0), .illegal(ill0), .state(st0)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; op = 6'h00; funct = 6'h20; Z = 1'b0;
    tick(); tick();
    chk("rst_state", int'(st1), 0);
    chk("rst_irwrite", int'(irw1), 0);
    chk("rst_pcen", int'(pcen1), 0);
    chk("rst_ula", int'(ula1), 2);

    // lw: 0,1,2,3,4,0
    rst = 1'b0; op = 6'h23; #1;
    chk("fetch_irwrite", int'(irw1), 1);
    chk("fetch_pcen", int'(pcen1), 1);
    chk("fetch_srcb", int'(srcb1), 1);
    chk("fetch_ula", int'(ula1), 2);
    tick();
    chk("lw_s1", int'(st1), 1);
    chk("lw_decode_srcb", int'(srcb1), 3);
    chk("lw_decode_regw", int'(regw1), 0);
    tick();
    chk("lw_s2", int'(st1), 2);
    chk("lw_memadr_srca", int'(srca1), 1);
    chk("lw_memadr_srcb", int'(srcb1), 2);
    tick();
    chk("lw_s3", int'(st1), 3);
    chk("lw_memread_iord", int'(iord1), 1);
    chk("lw_memread_regw", int'(regw1), 0);
    chk("lw_memread_m2r", int'(m2r1), 0);
    tick();
    chk("lw_s4", int'(st1), 4);
    chk("lw_memwb_regw", int'(regw1), 1);
    chk("lw_memwb_m2r", int'(m2r1), 1);
    chk("lw_memwb_regdst", int'(regdst1), 0);
    tick();
    chk("lw_done", int'(st1), 0);
    chk("lw_fetch_regw", int'(regw1), 0);

    // sw: 0,1,2,5,0
    op = 6'h2B;
    tick(); tick(); tick();
    chk("sw_s5", int'(st1), 5);
    chk("sw_memwrite", int'(memw1), 1);
    chk("sw_iord", int'(iord1), 1);
    tick();
    chk("sw_done", int'(st1), 0);

    // R-type slt
    op = 6'h00; funct = 6'h2A;
    tick(); tick();
    chk("slt_s6", int'(st1), 6);
    chk("slt_ula", int'(ula1), 7);
    chk("slt_srcb", int'(srcb1), 0);
    chk("slt_ill", int'(ill1), 0);
    tick();
    chk("slt_s7", int'(st1), 7);
    chk("slt_regdst", int'(regdst1), 1);
    chk("slt_regw", int'(regw1), 1);
    tick();
    chk("slt_done", int'(st1), 0);

    // R-type sub
    funct = 6'h22;
    tick(); tick();
    chk("sub_ula", int'(ula1), 6);
    tick(); tick();
    chk("sub_done", int'(st1), 0);

    // beq taken then not taken, 3 cycles each
    op = 6'h04; Z = 1'b1;
    tick(); tick();
    chk("beq1_s8", int'(st1), 8);
    chk("beq1_pcen", int'(pcen1), 1);
    chk("beq1_pcsrc", int'(pcsrc1), 1);
    chk("beq1_ula", int'(ula1), 6);
    tick();
    chk("beq1_done", int'(st1), 0);
    Z = 1'b0;
    tick(); tick();
    chk("beq0_s8", int'(st1), 8);
    chk("beq0_pcen", int'(pcen1), 0);
    tick();
    chk("beq0_done", int'(st1), 0);

    // addi: 0,1,9,10,0
    op = 6'h08;
    tick(); tick();
    chk("addi_s9", int'(st1), 9);
    chk("addi_srcb", int'(srcb1), 2);
    tick();
    chk("addi_s10", int'(st1), 10);
    chk("addi_regw", int'(regw1), 1);
    chk("addi_regdst", int'(regdst1), 0);
    tick();
    chk("addi_done", int'(st1), 0);

    // illegal opcode
    op = 6'h3F;
    tick();
    chk("illop_decode", int'(ill1), 1);
    tick();
    chk("illop_fetch", int'(st1), 0);
    chk("illop_clear", int'(ill1), 0);

    // illegal funct
    op = 6'h00; funct = 6'h01;
    tick();
    chk("illfn_decode", int'(ill1), 0);
    tick();
    chk("illfn_s6", int'(st1), 6);
    chk("illfn_exec", int'(ill1), 1);
    chk("illfn_regw", int'(regw1), 0);
    tick();
    chk("illfn_fetch", int'(st1), 0);
    chk("illfn_fetch_regw", int'(regw1), 0);

    // jump on both instances
    op = 6'h02;
    tick();
    chk("j_en_ill", int'(ill1), 0);
    chk("j_dis_ill", int'(ill0), 1);
    tick();
    chk("j_en_s11", int'(st1), 11);
    chk("j_en_pcsrc", int'(pcsrc1), 2);
    chk("j_en_pcen", int'(pcen1), 1);
    chk("j_dis_fetch", int'(st0), 0);
    tick();
    chk("j_en_done", int'(st1), 0);

    // reset mid-lw, in MEMREAD
    rst = 1'b1; op = 6'h23;
    tick();
    rst = 1'b0; #1;
    chk("resync_nj", int'(st0), 0);
    tick(); tick(); tick();
    chk("rstmid_s3", int'(st1), 3);
    rst = 1'b1; #1;
    chk("rstmid_memw", int'(memw1), 0);
    chk("rstmid_regw", int'(regw1), 0);
    chk("rstmid_pcen", int'(pcen1), 0);
    chk("rstmid_iord", int'(iord1), 0);
    tick();
    chk("rstmid_fetch", int'(st1), 0);
    chk("rstmid_ula", int'(ula1), 2);
    rst = 1'b0; #1;
    chk("rstmid_irw", int'(irw1), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
